// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus transmit sequencer feeding a UART: loads one byte, pulses tx_ready,
// waits for tx_done, then optionally idles GAP_CYCLES clocks before the next byte.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CYCLES = 0,
  parameter int GAP_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            tx_data,
  output logic                  tx_ready,
  input  logic                  tx_done,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [GAP_W-1:0]    GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [GAP_W-1:0]      gap_q;
  logic [7:0]            tx_data_q;
  logic                  tx_ready_q, overflow_q;
  state_t                state_q;
  logic                  wr_accept, pop;

  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign tx_data   = tx_data_q;
  assign tx_ready  = tx_ready_q;
  assign busy      = (state_q != IDLE);

  // full is evaluated before this cycle's pop, so a write while full is always dropped
  assign wr_accept = wr_en && !full;
  assign pop       = (state_q == IDLE) && !empty;

  always_comb begin
    count_d = count_q + (DEPTH_LOG2 + 1)'(wr_accept) - (DEPTH_LOG2 + 1)'(pop);
  end

  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      gap_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_ready_q <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      count_q <= count_d;
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (!empty) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            rd_ptr_q   <= rd_ptr_q + DEPTH_LOG2'(1);
            tx_ready_q <= 1'b1;
            state_q    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          tx_ready_q <= 1'b0;
          // a tx_done coinciding with our own tx_ready pulse belongs to a previous byte
          if (tx_done && !tx_ready_q) begin
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
            end else begin
              gap_q   <= GAP_RELOAD;
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
